// File: rtl/write_channel_ctrl_pkg.sv
// write_channel_ctrl_pkg: shared types and constants for the DMA write-channel sequencer
//   fsm_state_t        sequencer state encoding
//   CFG/DST_OFFSET     per-channel register offsets inside a CH_STRIDE-word block
//   BURST_*_MSB/LSB    field positions of AWBURST/AWSIZE in the config word
//   MAX_BEATS          largest legal AXI4 INCR burst length
package write_channel_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FETCH_CFG,
        FETCH_DST,
        LAUNCH,
        WAIT_RESP,
        DONE
    } fsm_state_t;
    localparam int unsigned CFG_OFFSET     = 1;
    localparam int unsigned DST_OFFSET     = 2;
    localparam int unsigned CH_STRIDE      = 4;
    localparam int unsigned BURST_TYPE_MSB = 26;
    localparam int unsigned BURST_TYPE_LSB = 25;
    localparam int unsigned BURST_SIZE_MSB = 24;
    localparam int unsigned BURST_SIZE_LSB = 22;
    localparam int unsigned MAX_BEATS      = 256;
endpackage

// File: rtl/write_channel_ctrl.sv
// write_channel_ctrl: fetches a channel's burst config/destination and launches one AXI4 write burst
//   arbWrite*            grant in (valid/channel/beats), done/error pulse out
//   dst_addr..beats      burst parameters held for the master controller
//   start_write          one-cycle launch pulse; write_transaction_completed/write_resp_error return
//   req/give             register-file port sharing with the CFG FSM
//   regFile_read*        register-file read port (data one cycle after strobe)
module write_channel_ctrl
    import write_channel_ctrl_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int REGFILE_ADDR_WIDTH = 8,
    parameter int REGFILE_DATA_WIDTH = 32,
    parameter int NUM_CHANNELS       = 32,
    localparam int CH_W              = $clog2(NUM_CHANNELS)
) (
    input  logic                          AXI_aclk,
    input  logic                          AXI_aresetn,
    input  logic                          arbWriteValid,
    input  logic [CH_W-1:0]               arbWriteChannel,
    input  logic [8:0]                    arbWriteBeats,
    output logic                          arbWriteDone,
    output logic                          arbWriteError,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] dst_addr,
    output logic [1:0]                    burst_type,
    output logic [2:0]                    burst_size,
    output logic [8:0]                    beats,
    output logic                          start_write,
    input  logic                          write_transaction_completed,
    input  logic                          write_resp_error,
    input  logic                          req,
    output logic                          give,
    output logic                          busy,
    output logic                          regFile_readEnable,
    output logic [REGFILE_ADDR_WIDTH-1:0] regFile_readAddr,
    input  logic [REGFILE_DATA_WIDTH-1:0] regFile_readData
);
    localparam int RA = REGFILE_ADDR_WIDTH;

    fsm_state_t                    state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [8:0]                    lat_beats_q, lat_beats_d;
    logic                          err_q, err_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic [1:0]                    burst_type_q, burst_type_d;
    logic [2:0]                    burst_size_q, burst_size_d;
    logic [8:0]                    beats_q, beats_d;
    logic                          start_write_q, start_write_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;
    logic                          give_q, give_d;
    logic                          busy_q, busy_d;
    logic [RA-1:0]                 ch_base;
    logic                          bad_beats;
    logic                          unused_rdata;

    assign ch_base   = RA'(RA'(ch_q) * RA'(CH_STRIDE));
    assign bad_beats = arbWriteBeats > 9'(MAX_BEATS);
    assign unused_rdata = &{1'b0, regFile_readData};

    always_comb begin
        state_d            = state_q;
        ch_d               = ch_q;
        lat_beats_d        = lat_beats_q;
        err_d              = err_q;
        dst_addr_d         = dst_addr_q;
        burst_type_d       = burst_type_q;
        burst_size_d       = burst_size_q;
        beats_d            = beats_q;
        start_write_d      = 1'b0;
        regFile_readEnable = 1'b0;
        regFile_readAddr   = '0;
        // Port is handed over only when no fetch is using it; a req seen
        // mid-fetch is simply held until WAIT_RESP.
        give_d = !req ? 1'b0 : (state_q == IDLE || state_q == WAIT_RESP) ? 1'b1 : give_q;
        case (state_q)
            IDLE: begin
                if (arbWriteValid && !req && !give_q) begin
                    ch_d        = arbWriteChannel;
                    lat_beats_d = arbWriteBeats;
                    err_d       = bad_beats;
                    state_d     = (arbWriteBeats == 9'd0 || bad_beats) ? DONE : FETCH_CFG;
                end
            end
            FETCH_CFG: begin
                regFile_readEnable = 1'b1;
                regFile_readAddr   = RA'(ch_base + RA'(CFG_OFFSET));
                state_d            = FETCH_DST;
            end
            FETCH_DST: begin
                // readData now carries the config word requested in FETCH_CFG
                regFile_readEnable = 1'b1;
                regFile_readAddr   = RA'(ch_base + RA'(DST_OFFSET));
                burst_type_d       = regFile_readData[BURST_TYPE_MSB:BURST_TYPE_LSB];
                burst_size_d       = regFile_readData[BURST_SIZE_MSB:BURST_SIZE_LSB];
                state_d            = LAUNCH;
            end
            LAUNCH: begin
                dst_addr_d    = regFile_readData[C_M_AXI_ADDR_WIDTH-1:0];
                beats_d       = lat_beats_q;
                start_write_d = 1'b1;
                state_d       = WAIT_RESP;
            end
            WAIT_RESP: begin
                // A completion coincident with the launch pulse belongs to an
                // older transaction and is discarded.
                if (write_transaction_completed && !start_write_q) begin
                    err_d   = write_resp_error;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d  = state_d == DONE;
        error_d = (state_d == DONE) && err_d;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            lat_beats_q   <= '0;
            err_q         <= 1'b0;
            dst_addr_q    <= '0;
            burst_type_q  <= '0;
            burst_size_q  <= '0;
            beats_q       <= '0;
            start_write_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            give_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            lat_beats_q   <= lat_beats_d;
            err_q         <= err_d;
            dst_addr_q    <= dst_addr_d;
            burst_type_q  <= burst_type_d;
            burst_size_q  <= burst_size_d;
            beats_q       <= beats_d;
            start_write_q <= start_write_d;
            done_q        <= done_d;
            error_q       <= error_d;
            give_q        <= give_d;
            busy_q        <= busy_d;
        end
    end

    assign arbWriteDone  = done_q;
    assign arbWriteError = error_q;
    assign dst_addr      = dst_addr_q;
    assign burst_type    = burst_type_q;
    assign burst_size    = burst_size_q;
    assign beats         = beats_q;
    assign start_write   = start_write_q;
    assign give          = give_q;
    assign busy          = busy_q;
endmodule
